// File: rtl/param_fault_copro.sv
// Fault-checking coprocessor: parity, TMR vote or checksum over a short word burst.
// Keeps a saturating count of faulty transactions and a sticky alarm.
module param_fault_copro #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 4,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] r0,
  input  logic [1:0]       check,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [WIDTH-1:0] result,
  output logic             fault,
  output logic             done,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             alarm
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL,
    REPORT
  } state_e;

  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] w_q [4];
  logic [WIDTH-1:0] result_q;
  logic             fault_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             alarm_q;
  logic             alarm_d;
  logic [WIDTH-1:0] res_c;
  logic             flt_c;
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] sum;
  logic [1:0]       last_idx;

  assign in_ready  = (state_q == IDLE) || (state_q == COLLECT);
  assign result    = result_q;
  assign fault     = fault_q;
  assign done      = done_q;
  assign fault_cnt = cnt_q;
  assign alarm     = alarm_q;

  assign last_idx = mode_q[0] ? 2'd3 : 2'd2;
  assign maj = (w_q[0] & w_q[1]) |
               (w_q[0] & w_q[2]) |
               (w_q[1] & w_q[2]);
  assign sum = w_q[0] + w_q[1] + w_q[2];

  always_comb begin
    res_c = w_q[0];
    flt_c = 1'b0;
    unique case (mode_q)
      2'b00: flt_c = ^w_q[0];
      2'b01: flt_c = ~^w_q[0];
      2'b10: begin
        res_c = maj;
        flt_c = (w_q[0] != maj) ||
                (w_q[1] != maj) ||
                (w_q[2] != maj);
      end
      2'b11: begin
        res_c = sum;
        flt_c = (sum != w_q[3]);
      end
      default: ;
    endcase
  end

  // clr dominates any increment landing on the same edge
  always_comb begin
    cnt_d   = cnt_q;
    alarm_d = alarm_q;
    if (state_q == EVAL && flt_c && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
    if (cnt_d >= THR)
      alarm_d = 1'b1;
    if (clr) begin
      cnt_d   = '0;
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= 2'b00;
      idx_q    <= 2'd0;
      result_q <= '0;
      fault_q  <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      alarm_q  <= 1'b0;
      for (int i = 0; i < 4; i++)
        w_q[i] <= '0;
    end else begin
      done_q  <= 1'b0;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mode_q  <= check;
            w_q[0]  <= r0;
            idx_q   <= 2'd1;
            state_q <= check[1] ? COLLECT : EVAL;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            w_q[idx_q] <= r0;
            idx_q      <= idx_q + 2'd1;
            if (idx_q == last_idx)
              state_q <= EVAL;
          end
        end
        EVAL: begin
          result_q <= res_c;
          fault_q  <= flt_c;
          done_q   <= 1'b1;
          state_q  <= REPORT;
        end
        REPORT: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_fault_copro.sv
// Bench for param_fault_copro: directed vector table, corner sequences
// and randomized transactions against a behavioural model.
module tb_param_fault_copro;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 2;
  localparam int THRESH = 3;
  localparam int CMAX   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] r0;
  logic [1:0]       check;
  logic             in_valid;
  logic             in_ready;
  logic             clr;
  logic [WIDTH-1:0] result;
  logic             fault;
  logic             done;
  logic [CNT_W-1:0] fault_cnt;
  logic             alarm;

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  bit m_alarm = 1'b0;

  param_fault_copro #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .THRESH(THRESH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .r0       (r0),
    .check    (check),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .clr      (clr),
    .result   (result),
    .fault    (fault),
    .done     (done),
    .fault_cnt(fault_cnt),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] w0, w1, w2, w3;
    logic [7:0] exp_res;
    logic       exp_flt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int popcount(input logic [7:0] v);
    int n = 0;
    for (int b = 0; b < 8; b++) n += int'(v[b]);
    return n;
  endfunction

  task automatic ref_eval(input logic [1:0] mode,
                          input logic [7:0] w0, w1, w2, w3,
                          output logic [7:0] res, output logic flt);
    int ones;
    res = w0;
    flt = 1'b0;
    if (mode == 2'b00) flt = (popcount(w0) % 2) == 1;
    else if (mode == 2'b01) flt = (popcount(w0) % 2) == 0;
    else if (mode == 2'b10) begin
      for (int b = 0; b < 8; b++) begin
        ones = int'(w0[b]) + int'(w1[b]) + int'(w2[b]);
        res[b] = ones >= 2;
      end
      flt = (w0 != res) || (w1 != res) || (w2 != res);
    end else begin
      res = 8'((int'(w0) + int'(w1) + int'(w2)) % 256);
      flt = res != w3;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_cnt = 0;
    m_alarm = 1'b0;
    chk("clr_cnt", int'(fault_cnt), 0);
    chk("clr_alarm", int'(alarm), 0);
  endtask

  // Runs one transaction from IDLE; done is due the cycle after EVAL.
  task automatic run_txn(input logic [1:0] mode,
                         input logic [7:0] w0, w1, w2, w3,
                         input int maxgap, input bit clr_at_eval,
                         output logic [7:0] got_res);
    logic [7:0] w [4];
    logic [7:0] eres;
    logic       eflt;
    int n;
    int guard;
    bit acc;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    n = mode[1] ? (mode[0] ? 4 : 3) : 1;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && maxgap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, maxgap)) begin
          r0 = 8'($urandom);
          check = 2'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      r0 = w[i];
      check = (i == 0) ? mode : 2'($urandom);
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 20) begin
        acc = in_ready;
        tick();
        guard++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    chk("done_in_eval", int'(done), 0);
    if (clr_at_eval) clr = 1'b1;
    tick();
    clr = 1'b0;
    ref_eval(mode, w0, w1, w2, w3, eres, eflt);
    if (clr_at_eval) begin
      m_cnt = 0;
      m_alarm = 1'b0;
    end else begin
      if (eflt && m_cnt < CMAX) m_cnt++;
      if (m_cnt >= THRESH) m_alarm = 1'b1;
    end
    chk("done_latency", int'(done), 1);
    chk("result", int'(result), int'(eres));
    chk("fault", int'(fault), int'(eflt));
    chk("fault_cnt", int'(fault_cnt), m_cnt);
    chk("alarm", int'(alarm), int'(m_alarm));
    got_res = result;
    tick();
    chk("done_pulse", int'(done), 0);
    chk("ready_idle", int'(in_ready), 1);
    chk("result_hold", int'(result), int'(eres));
  endtask

  vec_t vt [7];
  logic [7:0] r_a, r_b, r_x;
  bit saw_done;
  logic [1:0] rm;
  logic [7:0] a, b, c, d;

  initial begin
    vt[0] = '{2'b00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 1'b0};
    vt[1] = '{2'b00, 8'hA4, 8'h00, 8'h00, 8'h00, 8'hA4, 1'b1};
    vt[2] = '{2'b01, 8'hA4, 8'h00, 8'h00, 8'h00, 8'hA4, 1'b0};
    vt[3] = '{2'b10, 8'hF0, 8'hF1, 8'hF0, 8'h00, 8'hF0, 1'b1};
    vt[4] = '{2'b10, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h3C, 1'b0};
    vt[5] = '{2'b11, 8'h80, 8'h90, 8'h05, 8'h15, 8'h15, 1'b0};
    vt[6] = '{2'b11, 8'h80, 8'h90, 8'h05, 8'h16, 8'h15, 1'b1};

    reset = 1'b1;
    r0 = '0;
    check = '0;
    in_valid = 1'b0;
    clr = 1'b0;
    repeat (2) tick();
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_result", int'(result), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(fault_cnt), 0);
    chk("rst_alarm", int'(alarm), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_txn(vt[i].mode, vt[i].w0, vt[i].w1, vt[i].w2, vt[i].w3,
              0, 1'b0, r_x);
      chk("vec_result", int'(result), int'(vt[i].exp_res));
      chk("vec_fault", int'(fault), int'(vt[i].exp_flt));
    end
    chk("vec_alarm", int'(alarm), 1);
    do_clr();

    for (int i = 1; i <= 5; i++) begin
      run_txn(2'b00, 8'hA4, 8'h0, 8'h0, 8'h0, 0, 1'b0, r_x);
      chk("sat_cnt", int'(fault_cnt), (i < 3) ? i : 3);
      chk("sat_alarm", int'(alarm), int'(i >= 3));
    end
    do_clr();

    run_txn(2'b00, 8'hA4, 8'h0, 8'h0, 8'h0, 0, 1'b0, r_x);
    run_txn(2'b00, 8'hA4, 8'h0, 8'h0, 8'h0, 0, 1'b1, r_x);
    chk("clr_wins", int'(fault_cnt), 0);

    in_valid = 1'b1;
    check = 2'b10;
    r0 = 8'h11;
    tick();
    check = 2'b00;
    r0 = 8'h22;
    tick();
    r0 = 8'h33;
    reset = 1'b1;
    clr = 1'b0;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    m_cnt = 0;
    m_alarm = 1'b0;
    chk("abort_ready", int'(in_ready), 1);
    saw_done = 1'b0;
    repeat (5) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    chk("abort_no_done", int'(saw_done), 0);
    chk("abort_cnt", int'(fault_cnt), 0);
    chk("abort_result", int'(result), 0);

    run_txn(2'b10, 8'h5A, 8'h5B, 8'hDA, 8'h0, 0, 1'b0, r_a);
    run_txn(2'b10, 8'h5A, 8'h5B, 8'hDA, 8'h0, 4, 1'b0, r_b);
    chk("gap_equiv", int'(r_b), int'(r_a));
    run_txn(2'b11, 8'hFF, 8'h02, 8'h10, 8'h11, 3, 1'b0, r_x);

    for (int t = 0; t < 60; t++) begin
      rm = 2'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
      c = ($urandom_range(0, 1) == 1) ? a : 8'($urandom);
      d = 8'($urandom);
      if (rm == 2'b11 && $urandom_range(0, 1) == 1)
        d = 8'((int'(a) + int'(b) + int'(c)) % 256);
      run_txn(rm, a, b, c, d, $urandom_range(0, 2),
              $urandom_range(0, 9) == 0, r_x);
      if ($urandom_range(0, 14) == 0) do_clr();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
